// File: rtl/pe_array_conv3x3.sv
// 3x3 convolution PE array: three 8-pixel rows x 3x3 filter + bias -> six saturated 16-bit lanes.
// Two-stage pipeline (products, then adder tree). Optional ReLU on output: define PE_ARRAY_RELU_EN.
module pe_array_conv3x3 (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ifmapIn1,
  input  logic [63:0] ifmapIn2,
  input  logic [63:0] ifmapIn3,
  input  logic [71:0] filter,
  input  logic [15:0] bias,
  output logic [95:0] ofmap
);

  localparam int LANES = 6;
  localparam int TAPS  = 9;

  logic [63:0]        rows [3];
  logic signed [16:0] prod_next [LANES][TAPS];
  logic signed [16:0] prod_reg  [LANES][TAPS];
  logic signed [15:0] bias_reg;
  logic signed [15:0] lane_next [LANES];

  assign rows[0] = ifmapIn1;
  assign rows[1] = ifmapIn2;
  assign rows[2] = ifmapIn3;

  // Stage-1 multipliers: unsigned pixel (zero-extended to 9 bits) times signed weight.
  genvar gi, gk;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane_mul
      for (gk = 0; gk < TAPS; gk++) begin : g_tap
        localparam int R = gk / 3;
        localparam int C = gk % 3;
        logic signed [8:0] px;
        logic signed [7:0] wt;
        assign px = $signed({1'b0, rows[R][63-8*(gi+C) -: 8]});
        assign wt = $signed(filter[71-8*gk -: 8]);
        assign prod_next[gi][gk] = 17'(px * wt);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < LANES; j++)
        for (int k = 0; k < TAPS; k++)
          prod_reg[j][k] <= '0;
      bias_reg <= '0;
    end else begin
      for (int j = 0; j < LANES; j++)
        for (int k = 0; k < TAPS; k++)
          prod_reg[j][k] <= prod_next[j][k];
      bias_reg <= $signed(bias);
    end
  end

  // Stage-2 adder tree: 21 bits covers 9 worst-case products plus bias without overflow.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane_sum
      logic signed [20:0] sum_next;
      logic signed [15:0] sat_next;
      always_comb begin
        sum_next = {{5{bias_reg[15]}}, bias_reg};
        for (int k = 0; k < TAPS; k++)
          sum_next = sum_next + {{4{prod_reg[gi][k][16]}}, prod_reg[gi][k]};
      end
      always_comb begin
        if (sum_next > 21'sd32767)
          sat_next = 16'sh7FFF;
        else if (sum_next < -21'sd32768)
          sat_next = 16'sh8000;
        else
          sat_next = sum_next[15:0];
      end
`ifdef PE_ARRAY_RELU_EN
      assign lane_next[gi] = sat_next[15] ? 16'sh0000 : sat_next;
`else
      assign lane_next[gi] = sat_next;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ofmap <= '0;
    end else begin
      for (int j = 0; j < LANES; j++)
        ofmap[95-16*j -: 16] <= lane_next[j];
    end
  end

endmodule

// File: tb/tb_pe_array_conv3x3.sv
// Directed self-checking bench for pe_array_conv3x3 (honours PE_ARRAY_RELU_EN when defined).
module tb_pe_array_conv3x3;

  logic        clk;
  logic        rst;
  logic [63:0] ifmapIn1;
  logic [63:0] ifmapIn2;
  logic [63:0] ifmapIn3;
  logic [71:0] filter;
  logic [15:0] bias;
  logic [95:0] ofmap;

  int errors = 0;
  int checks = 0;

  pe_array_conv3x3 dut (
    .clk(clk), .rst(rst),
    .ifmapIn1(ifmapIn1), .ifmapIn2(ifmapIn2), .ifmapIn3(ifmapIn3),
    .filter(filter), .bias(bias), .ofmap(ofmap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed expectations for the reference vector (lane0 negative).
`ifdef PE_ARRAY_RELU_EN
  localparam logic [95:0] EXP_A = 96'h0000_03D5_0817_031E_01C9_01D8;
`else
  localparam logic [95:0] EXP_A = 96'hFC04_03D5_0817_031E_01C9_01D8;
`endif
  localparam logic [95:0] EXP_MAX = {6{16'h7FFF}};
`ifdef PE_ARRAY_RELU_EN
  localparam logic [95:0] EXP_MIN = 96'h0;
`else
  localparam logic [95:0] EXP_MIN = {6{16'h8000}};
`endif
  localparam logic [95:0] EXP_PACK = 96'h0000_0000_0000_0000_0000_0005;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] exp_val);
    checks++;
    if (ofmap !== exp_val) begin
      errors++;
      $display("FAIL %s: ofmap=%h expected=%h", name, ofmap, exp_val);
    end else begin
      $display("ok   %s: ofmap=%h", name, ofmap);
    end
  endtask

  task automatic load_zero();
    ifmapIn1 = '0; ifmapIn2 = '0; ifmapIn3 = '0; filter = '0; bias = '0;
  endtask

  task automatic load_a();
    ifmapIn1 = 64'h3913050100000000;
    ifmapIn2 = 64'h2B31390901010000;
    ifmapIn3 = 64'h1A2D391000000000;
    filter   = 72'hF9ED1A0DF1F4100AF1;
    bias     = 16'h01CB;
  endtask

  task automatic load_pack();
    ifmapIn1 = '0;
    ifmapIn2 = 64'h0000000000000005;
    ifmapIn3 = '0;
    filter   = 72'h000000000001000000;
    bias     = 16'h0000;
  endtask

  task automatic load_max();
    ifmapIn1 = '1; ifmapIn2 = '1; ifmapIn3 = '1;
    filter = {9{8'h7F}};
    bias   = 16'h7FFF;
  endtask

  task automatic load_min();
    ifmapIn1 = '1; ifmapIn2 = '1; ifmapIn3 = '1;
    filter = {9{8'h80}};
    bias   = 16'h8000;
  endtask

  task automatic test_reset();
    load_a();
    rst = 1'b1;
    step();
    check("reset_cycle1", 96'h0);
    step();
    check("reset_cycle2", 96'h0);
    load_zero();
    rst = 1'b0;
    step();
    check("reset_release", 96'h0);
    step();
    check("reset_zero_inputs", 96'h0);
  endtask

  task automatic test_conv();
    load_a();
    step();
    // after first edge the output must still hold the previous (zero) result
    check("conv_latency_edge1", 96'h0);
    step();
    check("conv_vector_a", EXP_A);
  endtask

  task automatic test_saturation();
    load_max();
    step(); step();
    check("sat_positive", EXP_MAX);
    load_min();
    step(); step();
    check("sat_negative", EXP_MIN);
  endtask

  task automatic test_packing();
    load_pack();
    step(); step();
    check("packing_w12_x1p7", EXP_PACK);
  endtask

  task automatic test_back_to_back();
    load_zero();
    step(); step();
    load_a();
    step();
    load_pack();
    step();
    check("b2b_a", EXP_A);
    load_max();
    step();
    check("b2b_b", EXP_PACK);
    load_zero();
    step();
    check("b2b_c", EXP_MAX);
    step();
    check("b2b_drain", 96'h0);
  endtask

  task automatic test_reset_inflight();
    load_a();
    step();
    load_pack();
    step();
    check("flush_a_out", EXP_A);
    load_zero();
    rst = 1'b1;
    step();
    check("flush_rst_clears", 96'h0);
    rst = 1'b0;
    step();
    check("flush_b_lost", 96'h0);
    load_max();
    step();
    check("flush_after_zero", 96'h0);
    step();
    check("flush_recover", EXP_MAX);
  endtask

  initial begin
    rst = 1'b1;
    load_zero();
    #2;
    test_reset();
    test_conv();
    test_saturation();
    test_packing();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
